// File: rtl/mips_cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_bus_arbiter
//  Description : Shares one Avalon-style memory bus between the CPU
//                instruction-fetch port (i_*) and load/store port (d_*).
//                Grants are registered in a small FSM. The granted port is
//                passed through to the bus combinationally. A starvation
//                counter stops data priority from locking out fetch.
//  Ports       : clk, reset       - clock, synchronous active-high reset
//                i_*              - fetch port (address, read, waitrequest, readdata)
//                d_*              - load/store port (address, read, write,
//                                   writedata, byteenable, waitrequest, readdata)
//                address .. readdata - RAM-side Avalon bus
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_bus_arbiter #(
    parameter int PRIORITY_DATA = 1,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    // fetch port
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    // load/store port
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    // RAM bus
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GNT_I = 2'd1;
    localparam logic [1:0] S_GNT_D = 2'd2;

    localparam logic [3:0] C_STARVE_LIMIT = STARVE_LIMIT[3:0];

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_last_grant_d;   // 1: most recent completed transfer was D
    logic [3:0] r_starve_cnt;

    logic       w_req_i;
    logic       w_req_d;
    logic       w_done_i;
    logic       w_done_d;
    logic       w_grant_i;

    assign w_req_i = i_read;
    assign w_req_d = d_read | d_write;

    // Read data is broadcast; only the granted port qualifies it.
    assign i_readdata = readdata;
    assign d_readdata = readdata;

    assign w_grant_i = (r_state == S_IDLE) && (w_state_next == S_GNT_I);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_last_grant_d <= 1'b1;
            r_starve_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;

            if (w_done_i) begin
                r_last_grant_d <= 1'b0;
            end else if (w_done_d) begin
                r_last_grant_d <= 1'b1;
            end

            if (w_grant_i) begin
                r_starve_cnt <= 4'd0;
            end else if (w_done_d) begin
                if (!w_req_i) begin
                    r_starve_cnt <= 4'd0;
                end else if (r_starve_cnt != C_STARVE_LIMIT) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_done_i      = 1'b0;
        w_done_d      = 1'b0;
        address       = 32'd0;
        read          = 1'b0;
        write         = 1'b0;
        writedata     = 32'd0;
        byteenable    = 4'd0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (w_req_i && w_req_d) begin
                    if (PRIORITY_DATA != 0) begin
                        w_state_next = (r_starve_cnt == C_STARVE_LIMIT) ? S_GNT_I : S_GNT_D;
                    end else begin
                        w_state_next = r_last_grant_d ? S_GNT_I : S_GNT_D;
                    end
                end else if (w_req_i) begin
                    w_state_next = S_GNT_I;
                end else if (w_req_d) begin
                    w_state_next = S_GNT_D;
                end
            end

            S_GNT_I: begin
                // Fetch is always a full-word read.
                address       = i_address;
                read          = i_read;
                byteenable    = 4'hF;
                i_waitrequest = waitrequest;
                w_done_i      = i_read && !waitrequest;
                // Completion or an abandoned request both return to IDLE.
                if (w_done_i || !i_read) begin
                    w_state_next = S_IDLE;
                end
            end

            S_GNT_D: begin
                address       = d_address;
                // A simultaneous read+write from the core forwards the write only.
                read          = d_read & ~d_write;
                write         = d_write;
                writedata     = d_writedata;
                byteenable    = d_byteenable;
                d_waitrequest = waitrequest;
                w_done_d      = w_req_d && !waitrequest;
                if (w_done_d || !w_req_d) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_cpu_bus_arbiter
//  Description : Directed self-checking bench for mips_cpu_bus_arbiter.
//                u_dut uses data priority and drives a small RAM model;
//                u_dut_rr uses round-robin and shares the same port stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] i_address;
    logic        i_read;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        waitrequest;

    logic        i_waitrequest, d_waitrequest;
    logic [31:0] i_readdata, d_readdata;
    logic [31:0] address, writedata;
    logic        read, write;
    logic [3:0]  byteenable;
    logic [31:0] ram_rdata;

    logic        rr_i_waitrequest, rr_d_waitrequest;
    logic [31:0] rr_i_readdata, rr_d_readdata;
    logic [31:0] rr_address, rr_writedata;
    logic        rr_read, rr_write;
    logic [3:0]  rr_byteenable;
    logic [31:0] rr_rdata;

    logic [31:0] mem [16];
    int          wr_count;

    int          n_tests;
    int          n_fail;

    mips_cpu_bus_arbiter #(.PRIORITY_DATA(1), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(ram_rdata)
    );

    mips_cpu_bus_arbiter #(.PRIORITY_DATA(0), .STARVE_LIMIT(4)) u_dut_rr (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read),
        .i_waitrequest(rr_i_waitrequest), .i_readdata(rr_i_readdata),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(rr_d_waitrequest), .d_readdata(rr_d_readdata),
        .address(rr_address), .read(rr_read), .write(rr_write),
        .writedata(rr_writedata), .byteenable(rr_byteenable),
        .waitrequest(waitrequest), .readdata(rr_rdata)
    );

    assign rr_rdata  = 32'h0;
    assign ram_rdata = mem[address[5:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: word i preloads to 0x10000000+i; byte-lane writes on completion.
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'h1000_0000 + k;
            wr_count <= 0;
        end else if (write && !waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) mem[address[5:2]][b*8 +: 8] <= writedata[b*8 +: 8];
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int d_grants, i_grants, first_i;
    int wc0;
    logic [31:0] seq;   // one bit per grant, 1 = I

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b1; i_address = 32'h0; i_read = 1'b0;
        d_address = 32'h0; d_read = 1'b0; d_write = 1'b0;
        d_writedata = 32'h0; d_byteenable = 4'h0; waitrequest = 1'b0;
        tick(); tick();
        check("rst_read",  {31'd0, read}, 32'd0);
        check("rst_write", {31'd0, write}, 32'd0);
        check("rst_addr",  address, 32'd0);
        check("rst_iwait", {31'd0, i_waitrequest}, 32'd1);
        check("rst_dwait", {31'd0, d_waitrequest}, 32'd1);
        reset = 1'b0;
        tick();

        // Single fetch
        i_read = 1'b1; i_address = 32'hBFC0_0000;
        #1;
        check("f_idle_read", {31'd0, read}, 32'd0);
        tick();
        check("f_read",   {31'd0, read}, 32'd1);
        check("f_addr",   address, 32'hBFC0_0000);
        check("f_iwait",  {31'd0, i_waitrequest}, 32'd0);
        check("f_dwait",  {31'd0, d_waitrequest}, 32'd1);
        check("f_rdata",  i_readdata, 32'h1000_0000);
        tick();
        check("f_done_idle", {31'd0, read}, 32'd0);
        i_read = 1'b0;
        tick();

        // Simultaneous requests, data priority: D at cycle 1, I at cycle 3
        i_read = 1'b1; i_address = 32'h0000_000C; d_read = 1'b1; d_address = 32'h0000_0004;
        tick();
        check("s_c1_dwait", {31'd0, d_waitrequest}, 32'd0);
        check("s_c1_iwait", {31'd0, i_waitrequest}, 32'd1);
        check("s_c1_addr",  address, 32'h0000_0004);
        check("s_c1_rdata", d_readdata, 32'h1000_0001);
        tick();
        d_read = 1'b0;
        check("s_c2_iwait", {31'd0, i_waitrequest}, 32'd1);
        tick();
        check("s_c3_iwait", {31'd0, i_waitrequest}, 32'd0);
        check("s_c3_rdata", i_readdata, 32'h1000_0003);
        tick();
        i_read = 1'b0;
        tick();

        // Starvation: continuous D with I pending -> four D grants then I
        i_read = 1'b1; d_read = 1'b1;
        d_grants = 0; i_grants = 0; first_i = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (!d_waitrequest && i_grants == 0) d_grants++;
            if (!i_waitrequest) begin
                i_grants++;
                if (first_i == 0) first_i = c;
            end
        end
        i_read = 1'b0; d_read = 1'b0;
        check("st_d_grants", d_grants, 32'd4);
        check("st_i_grants", i_grants, 32'd1);
        check("st_i_cycle",  first_i, 32'd9);
        tick();

        // RAM stall on a write; bus held for 4 cycles, one write completes
        wc0 = wr_count;
        d_write = 1'b1; d_address = 32'h0000_0008; d_writedata = 32'hBA6A_0000;
        d_byteenable = 4'hF; waitrequest = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 4) waitrequest = 1'b0;
            #1;
            check($sformatf("w_write%0d", c), {31'd0, write}, 32'd1);
            check($sformatf("w_addr%0d", c), address, 32'h0000_0008);
            check($sformatf("w_data%0d", c), writedata, 32'hBA6A_0000);
            check($sformatf("w_dwait%0d", c), {31'd0, d_waitrequest}, (c == 4) ? 32'd0 : 32'd1);
        end
        tick();
        d_write = 1'b0;
        check("w_idle", {31'd0, write}, 32'd0);
        check("w_count", wr_count - wc0, 32'd1);
        i_read = 1'b1; i_address = 32'h0000_0008;
        tick();
        check("w_readback", i_readdata, 32'hBA6A_0000);
        tick();
        i_read = 1'b0;
        tick();

        // Granted fetch dropped while stalled: strobe follows, back to IDLE
        i_read = 1'b1; i_address = 32'h0; waitrequest = 1'b1;
        tick();
        i_read = 1'b0;
        #1;
        check("drop_read", {31'd0, read}, 32'd0);
        tick();
        check("drop_idle_iwait", {31'd0, i_waitrequest}, 32'd1);
        waitrequest = 1'b0;

        // Illegal read+write: write forwarded, read masked; reset mid-transfer
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h4; waitrequest = 1'b1;
        tick();
        check("rw_read",  {31'd0, read}, 32'd0);
        check("rw_write", {31'd0, write}, 32'd1);
        reset = 1'b1;
        tick();
        check("mrst_write", {31'd0, write}, 32'd0);
        check("mrst_read",  {31'd0, read}, 32'd0);
        check("mrst_iwait", {31'd0, i_waitrequest}, 32'd1);
        check("mrst_dwait", {31'd0, d_waitrequest}, 32'd1);
        reset = 1'b0; d_read = 1'b0; d_write = 1'b0; waitrequest = 1'b0;
        tick();

        // Post-reset simultaneous requests: priority DUT -> D; round-robin alternates I,D,I,D
        i_read = 1'b1; d_read = 1'b1; i_address = 32'h0; d_address = 32'h4;
        seq = 32'h0; i_grants = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) check("pr_first_d", {31'd0, d_waitrequest}, 32'd0);
            if (!rr_i_waitrequest) begin seq[i_grants] = 1'b1; i_grants++; end
            else if (!rr_d_waitrequest) begin seq[i_grants] = 1'b0; i_grants++; end
        end
        i_read = 1'b0; d_read = 1'b0;
        check("rr_n_grants", i_grants, 32'd4);
        check("rr_pattern",  {28'd0, seq[3:0]}, 32'h5);   // grant0=I, 1=D, 2=I, 3=D
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
